// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Used for both the preset and the step so the two paths clamp the same way.
    function automatic int unsigned clamp_max(input int unsigned value, input int unsigned max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count datapath: modulo add/subtract with wrap detection.
// COUNTER_SAT_EN: when defined, sat_i=1 turns a wrapping step into a clamp at MAX or 0.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned N   = 5,
    parameter int unsigned MAX = (2**N) - 1
) (
    input  logic [N-1:0] cur_i,
    input  logic [N-1:0] step_i,
    input  logic         dir_i,
    input  logic         sat_i,
    output logic [N-1:0] nxt_o,
    output logic         wrap_o
);

    // One extra bit keeps cur+step and cur+MAX+1 from overflowing even at MAX = 2**N-1.
    localparam logic [N:0]   MODULUS = (N+1)'(MAX + 1);
    localparam logic [N:0]   MAX_W   = (N+1)'(MAX);
    localparam logic [N-1:0] MAX_N   = N'(MAX);

    logic [N:0] cur_w;
    logic [N:0] step_w;
    logic [N:0] raw_w;
    logic       cross_w;

    always_comb begin
        cur_w   = {1'b0, cur_i};
        step_w  = {1'b0, step_i};
        raw_w   = cur_w;
        cross_w = 1'b0;
        if (dir_i == DIR_UP) begin
            raw_w   = cur_w + step_w;
            cross_w = (raw_w > MAX_W);
            if (cross_w) raw_w = raw_w - MODULUS;
        end else begin
            cross_w = (step_w > cur_w);
            raw_w   = cross_w ? (cur_w + MODULUS - step_w) : (cur_w - step_w);
        end

        nxt_o  = N'(raw_w);
        wrap_o = cross_w;
`ifdef COUNTER_SAT_EN
        if (sat_i && cross_w) begin
            nxt_o  = (dir_i == DIR_UP) ? MAX_N : '0;
            wrap_o = 1'b0;
        end
`endif
    end

`ifndef COUNTER_SAT_EN
    logic unused_sat;
    assign unused_sat = sat_i;
`endif

endmodule

// File: rtl/counter_ud_mod.sv
// N-bit up/down modulo counter: load > enable > hold, registered out and wrap pulse.
// COUNTER_SAT_EN: when defined, the sat input clamps instead of wrapping.
module counter_ud_mod
    import counter_pkg::*;
#(
    parameter int unsigned N       = 5,
    parameter int unsigned MAX     = (2**N) - 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] preset,
    input  logic         dir,
    input  logic [N-1:0] step,
    input  logic         sat,
    output logic [N-1:0] out,
    output logic         tc,
    output logic         wrap
);

    localparam logic [N-1:0] MAX_N = N'(MAX);
    localparam logic [N-1:0] RST_N = N'(RST_VAL);

    logic [N-1:0] out_q,  out_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] step_eff;
    logic [N-1:0] load_val;
    logic [N-1:0] nxt;
    logic         nxt_wrap;

    assign step_eff = N'(clamp_max(32'(step),   MAX));
    assign load_val = N'(clamp_max(32'(preset), MAX));

    counter_next #(
        .N   (N),
        .MAX (MAX)
    ) u_next (
        .cur_i  (out_q),
        .step_i (step_eff),
        .dir_i  (dir),
        .sat_i  (sat),
        .nxt_o  (nxt),
        .wrap_o (nxt_wrap)
    );

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (en) begin
            out_d  = nxt;
            wrap_d = nxt_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= RST_N;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    // tc follows dir combinationally so a direction change shows up at once.
    assign tc   = ((dir == DIR_UP) && (out_q == MAX_N)) || ((dir == DIR_DOWN) && (out_q == '0));
    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_ud_mod.sv
// Scoreboard bench for counter_ud_mod at N=5, MAX=23, RST_VAL=0.
module tb_counter_ud_mod;

    typedef struct packed {
        logic [4:0] o;
        logic       w;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1, load = 1'b0, dir = 1'b1, sat = 1'b0;
    logic [4:0] preset = '0, step = 5'd1;
    logic [4:0] out;
    logic       tc, wrap;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    always #5 clk = ~clk;

    counter_ud_mod #(.N(5), .MAX(23), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .preset(preset),
        .dir(dir), .step(step), .sat(sat), .out(out), .tc(tc), .wrap(wrap)
    );

    function automatic void chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
        end
    endfunction

    // Monitor: every cycle the counter presents a new registered value.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out",  n_out, int'(out),  int'(e.o));
                chk("wrap", n_out, int'(wrap), int'(e.w));
                chk("tc",   n_out, int'(tc),   int'(e.t));
                n_out++;
            end
        end
    end

    task automatic cyc(input logic r, input logic ld, input logic e, input logic d,
                       input logic [4:0] pre, input logic [4:0] st, input logic s,
                       input logic [4:0] eo, input logic ew, input logic et);
        @(negedge clk); #1;
        rst = r; load = ld; en = e; dir = d; preset = pre; step = st; sat = s;
        @(posedge clk);
        sb.push_back(exp_t'{o: eo, w: ew, t: et});
    endtask

    initial begin
        int guard;
        logic [4:0] v;
        // Reset held with en=1.
        #1;
        chk("rst_init_out", 0, int'(out), 0);
        chk("rst_init_wrap", 0, int'(wrap), 0);
        repeat (3) cyc(0, 0, 1, 1, 5'd0, 5'd1, 0, 5'd0, 0, 0);

        // Up-count step 1 through the wrap.
        for (int i = 1; i <= 24; i++) begin
            v = 5'(i % 24);
            cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, v, (i == 24), (v == 5'd23));
        end

        // Reset mid-count at 9 takes effect before the next edge.
        cyc(1, 1, 0, 1, 5'd8, 5'd1, 0, 5'd8, 0, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd9, 0, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_out", 0, int'(out), 0);
        chk("rst_mid_wrap", 0, int'(wrap), 0);
        cyc(0, 0, 1, 1, 5'd0, 5'd1, 0, 5'd0, 0, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd1, 0, 0);

        // Step arithmetic.
        cyc(1, 1, 0, 1, 5'd20, 5'd5, 0, 5'd20, 0, 0);
        cyc(1, 0, 1, 1, 5'd0,  5'd5, 0, 5'd1,  1, 0);
        cyc(1, 1, 0, 0, 5'd3,  5'd5, 0, 5'd3,  0, 0);
        cyc(1, 0, 1, 0, 5'd0,  5'd5, 0, 5'd22, 1, 0);
        cyc(1, 1, 0, 1, 5'd5,  5'd30, 0, 5'd5, 0, 0);
        cyc(1, 0, 1, 1, 5'd0,  5'd30, 0, 5'd4, 1, 0);
        cyc(1, 0, 1, 0, 5'd0,  5'd30, 0, 5'd5, 1, 0);
        cyc(1, 0, 1, 0, 5'd0,  5'd0,  0, 5'd5, 0, 0);

        // Load priority and clamp.
        cyc(1, 1, 1, 1, 5'd11, 5'd1, 0, 5'd11, 0, 0);
        cyc(1, 1, 1, 1, 5'd31, 5'd1, 0, 5'd23, 0, 1);

        // Direction change and tc.
        cyc(1, 1, 0, 1, 5'd5, 5'd1, 0, 5'd5, 0, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd6, 0, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd7, 0, 0);
        for (int i = 6; i >= 0; i--)
            cyc(1, 0, 1, 0, 5'd0, 5'd1, 0, 5'(i), 0, (i == 0));
        cyc(1, 0, 0, 1, 5'd0, 5'd1, 0, 5'd0, 0, 0);
        cyc(1, 0, 0, 0, 5'd0, 5'd1, 0, 5'd0, 0, 1);
        cyc(1, 0, 1, 0, 5'd0, 5'd1, 0, 5'd23, 1, 0);

        // Saturation stimulus; expectations depend on the build.
        cyc(1, 1, 0, 1, 5'd21, 5'd4, 1, 5'd21, 0, 0);
`ifdef COUNTER_SAT_EN
        cyc(1, 0, 1, 1, 5'd0, 5'd4, 1, 5'd23, 0, 1);
        cyc(1, 0, 1, 1, 5'd0, 5'd4, 1, 5'd23, 0, 1);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd0,  1, 0);
        cyc(1, 1, 0, 0, 5'd2, 5'd4, 1, 5'd2,  0, 0);
        cyc(1, 0, 1, 0, 5'd0, 5'd4, 1, 5'd0,  0, 1);
`else
        cyc(1, 0, 1, 1, 5'd0, 5'd4, 1, 5'd1,  1, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd4, 1, 5'd5,  0, 0);
        cyc(1, 0, 1, 1, 5'd0, 5'd1, 0, 5'd6,  0, 0);
        cyc(1, 1, 0, 0, 5'd2, 5'd4, 1, 5'd2,  0, 0);
        cyc(1, 0, 1, 0, 5'd0, 5'd4, 1, 5'd22, 1, 0);
`endif

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
